// File: rtl/stream_adder_arbiter_pkg.sv
// rtl/stream_adder_arbiter_pkg.sv - shared constants and width helpers for stream_adder_arbiter
package stream_arb_pkg;

  localparam int MIN_FIFO_DEPTH = 3;
  localparam int PIPE_DEPTH     = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int ch_width(input int num_ch);
    return (num_ch < 2) ? 1 : clog2(num_ch);
  endfunction

endpackage

// File: rtl/stream_adder_arbiter_if.sv
// rtl/stream_adder_arbiter_if.sv - operand request streams and result stream of stream_adder_arbiter
interface stream_adder_arbiter_if
  import stream_arb_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 16
);
  localparam int CH_W = ch_width(NUM_CH);

  logic [NUM_CH*DATA_WIDTH-1:0] s_a_tdata;
  logic [NUM_CH*DATA_WIDTH-1:0] s_b_tdata;
  logic [NUM_CH-1:0]            s_tvalid;
  logic [NUM_CH-1:0]            s_tready;
  logic [DATA_WIDTH-1:0]        m_tdata;
  logic [CH_W-1:0]              m_tuser;
  logic                         m_tvalid;
  logic                         m_tready;

  modport master (
    output s_a_tdata, s_b_tdata, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tuser, m_tvalid
  );

  modport slave (
    input  s_a_tdata, s_b_tdata, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tuser, m_tvalid
  );

endinterface

// File: rtl/stream_adder_arbiter_rr_arbiter.sv
// rtl/stream_adder_arbiter_rr_arbiter.sv - round-robin search from a registered pointer
module rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              grant_any
);

  always_comb begin
    int              c;
    logic [CH_W-1:0] sel;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    c         = 0;
    sel       = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      c   = (int'(ptr) + off) % NUM_CH;
      sel = CH_W'(c);
      if (!grant_any && req[sel]) begin
        grant[sel] = 1'b1;
        grant_idx  = sel;
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_adder_arbiter.sv
// rtl/stream_adder_arbiter.sv - shared registered adder with round-robin input arbitration and output FIFO
// Optional per-channel accept counters: STREAM_ARB_STATS_EN
module stream_adder_arbiter
  import stream_arb_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  stream_adder_arbiter_if.slave bus
`ifdef STREAM_ARB_STATS_EN
  ,
  output logic [NUM_CH*32-1:0]  grant_cnt
`endif
);

  localparam int CH_W  = ch_width(NUM_CH);
  localparam int DEPTH = (FIFO_DEPTH < MIN_FIFO_DEPTH) ? MIN_FIFO_DEPTH : FIFO_DEPTH;
  localparam int AW    = clog2(DEPTH);
  localparam int OCC_W = clog2(DEPTH + PIPE_DEPTH + 1);

  typedef logic [CH_W-1:0]       ch_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [AW-1:0]         addr_t;
  typedef logic [OCC_W-1:0]      occ_t;

  logic  run_q, run_d;
  ch_t   ptr_q, ptr_d;
  logic  iss_v_q, iss_v_d;
  data_t iss_a_q, iss_a_d, iss_b_q, iss_b_d;
  ch_t   iss_id_q, iss_id_d;
  logic  add_v_q, add_v_d;
  data_t add_sum_q, add_sum_d;
  ch_t   add_id_q, add_id_d;
  data_t mem_data_q [DEPTH];
  data_t mem_data_d [DEPTH];
  ch_t   mem_id_q [DEPTH];
  ch_t   mem_id_d [DEPTH];
  addr_t wr_q, wr_d, rd_q, rd_d;
  occ_t  occ_q, occ_d;

  logic [NUM_CH-1:0] grant;
  ch_t               grant_idx;
  logic              grant_any;
  logic              credit, accept, push, pop;
  occ_t              inflight;

  rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_rr_arbiter (
    .req       (bus.s_tvalid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  function automatic addr_t next_addr(input addr_t a);
    return (a == addr_t'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  // Every accepted pair owns a FIFO slot from issue until it is popped, so a push never hits a full FIFO.
  always_comb begin
    inflight     = occ_t'(iss_v_q) + occ_t'(add_v_q);
    credit       = run_q && ((occ_q + inflight) < occ_t'(DEPTH));
    accept       = credit && grant_any;
    push         = add_v_q;
    pop          = (occ_q != '0) && bus.m_tready;
    bus.s_tready = credit ? grant : '0;
    bus.m_tvalid = (occ_q != '0);
    bus.m_tdata  = (occ_q != '0) ? mem_data_q[rd_q] : '0;
    bus.m_tuser  = (occ_q != '0) ? mem_id_q[rd_q] : '0;
  end

  always_comb begin
    run_d    = 1'b1;
    ptr_d    = ptr_q;
    iss_v_d  = accept;
    iss_a_d  = iss_a_q;
    iss_b_d  = iss_b_q;
    iss_id_d = iss_id_q;
    if (accept) begin
      ptr_d    = (grant_idx == ch_t'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
      iss_a_d  = bus.s_a_tdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      iss_b_d  = bus.s_b_tdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      iss_id_d = grant_idx;
    end

    add_v_d   = iss_v_q;
    add_sum_d = iss_a_q + iss_b_q;
    add_id_d  = iss_id_q;

    mem_data_d = mem_data_q;
    mem_id_d   = mem_id_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    if (push) begin
      mem_data_d[wr_q] = add_sum_q;
      mem_id_d[wr_q]   = add_id_q;
      wr_d             = next_addr(wr_q);
    end
    if (pop) rd_d = next_addr(rd_q);
    occ_d = occ_q + occ_t'(push) - occ_t'(pop);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_q     <= 1'b0;
      ptr_q     <= '0;
      iss_v_q   <= 1'b0;
      iss_a_q   <= '0;
      iss_b_q   <= '0;
      iss_id_q  <= '0;
      add_v_q   <= 1'b0;
      add_sum_q <= '0;
      add_id_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_id_q[i]   <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      run_q      <= run_d;
      ptr_q      <= ptr_d;
      iss_v_q    <= iss_v_d;
      iss_a_q    <= iss_a_d;
      iss_b_q    <= iss_b_d;
      iss_id_q   <= iss_id_d;
      add_v_q    <= add_v_d;
      add_sum_q  <= add_sum_d;
      add_id_q   <= add_id_d;
      mem_data_q <= mem_data_d;
      mem_id_q   <= mem_id_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      occ_q      <= occ_d;
    end
  end

`ifdef STREAM_ARB_STATS_EN
  logic [31:0] gcnt_q [NUM_CH];
  logic [31:0] gcnt_d [NUM_CH];

  always_comb begin
    gcnt_d = gcnt_q;
    if (accept) gcnt_d[grant_idx] = gcnt_q[grant_idx] + 32'd1;
    for (int i = 0; i < NUM_CH; i++) grant_cnt[i*32 +: 32] = gcnt_q[i];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CH; i++) gcnt_q[i] <= '0;
    end else begin
      gcnt_q <= gcnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_stream_adder_arbiter.sv
// tb/tb_stream_adder_arbiter.sv - scoreboard bench for stream_adder_arbiter
module tb_stream_adder_arbiter;

  localparam int NCH = 4;
  localparam int DW  = 16;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  stream_adder_arbiter_if #(.NUM_CH(NCH), .DATA_WIDTH(DW)) bus ();

`ifdef STREAM_ARB_STATS_EN
  logic [NCH*32-1:0] grant_cnt;
`endif

  stream_adder_arbiter #(.NUM_CH(NCH), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
`ifdef STREAM_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  typedef struct {
    logic [DW-1:0] sum;
    int            ch;
    int            acc;
  } exp_t;

  exp_t          sb[$];
  int            grants[$];
  int            n_checks = 0;
  int            n_pass = 0;
  int            cyc = 0;
  int            outstanding = 0;
  int            exp_ptr = 0;
  int            beats = 0;
  int            last_user = 0;
  logic [DW-1:0] last_data;
  logic [DW-1:0] a_val [NCH];
  logic [DW-1:0] b_val [NCH];
  logic [NCH-1:0] mask;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < NCH; i++) begin
      bus.s_a_tdata[i*DW +: DW] = a_val[i];
      bus.s_b_tdata[i*DW +: DW] = b_val[i];
    end
    bus.s_tvalid = mask;
  endtask

  // One clock: predict arbitration/credit, check outputs at negedge, then advance the model.
  task automatic step();
    int             win;
    logic [NCH-1:0] exp_vec;
    logic           exp_mv;
    logic           popped;
    logic [DW-1:0]  s;
    @(negedge clk);
    win = -1;
    if (outstanding < 4) begin
      for (int k = 0; k < NCH; k++) begin
        int c;
        c = (exp_ptr + k) % NCH;
        if (win < 0 && mask[c]) win = c;
      end
    end
    exp_vec = '0;
    if (win >= 0) exp_vec[win] = 1'b1;
    chk("s_tready", bus.s_tready, exp_vec);
    for (int k = 0; k < NCH; k++)
      if (bus.s_tready[k] && mask[k]) grants.push_back(k);
    exp_mv = (sb.size() > 0) && (cyc >= sb[0].acc + 3);
    chk("m_tvalid", bus.m_tvalid, exp_mv);
    popped = 1'b0;
    if (exp_mv && bus.m_tvalid) begin
      chk("m_tdata", bus.m_tdata, sb[0].sum);
      chk("m_tuser", bus.m_tuser, sb[0].ch);
      if (bus.m_tready) begin
        last_data = bus.m_tdata;
        last_user = int'(bus.m_tuser);
        beats++;
        void'(sb.pop_front());
        popped = 1'b1;
      end
    end
    if (win >= 0) begin
      s = a_val[win] + b_val[win];
      sb.push_back('{s, win, cyc});
    end
    @(posedge clk);
    cyc++;
    if (popped) outstanding--;
    if (win >= 0) begin
      outstanding++;
      exp_ptr    = (win + 1) % NCH;
      a_val[win] = DW'($urandom);
      b_val[win] = DW'($urandom);
    end
    #1 drive();
  endtask

  task automatic drain();
    int n;
    n    = 0;
    mask = '0;
    drive();
    while (sb.size() > 0 && n < 60) begin
      step();
      n++;
    end
    chk("drain_done", sb.size(), 0);
  endtask

  task automatic do_reset();
    #2 resetn = 1'b0;
    #1;
    chk("rst_m_tvalid", bus.m_tvalid, 0);
    chk("rst_s_tready", bus.s_tready, 0);
    chk("rst_m_tdata", bus.m_tdata, 0);
    chk("rst_m_tuser", bus.m_tuser, 0);
    sb.delete();
    outstanding = 0;
    exp_ptr     = 0;
    mask        = '0;
    drive();
    @(posedge clk);
    cyc++;
    #1 resetn = 1'b1;
    step();
  endtask

  task automatic one_shot(input int ch, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] exp);
    beats        = 0;
    a_val[ch]    = a;
    b_val[ch]    = b;
    mask         = '0;
    mask[ch]     = 1'b1;
    bus.m_tready = 1'b1;
    drive();
    step();
    mask = '0;
    drive();
    drain();
    chk("one_shot_sum", last_data, exp);
    chk("one_shot_user", last_user, ch);
    chk("one_shot_beats", beats, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    resetn       = 1'b0;
    mask         = '1;
    bus.m_tready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      a_val[i] = DW'($urandom);
      b_val[i] = DW'($urandom);
    end
    drive();
    @(posedge clk);
    do_reset();

    one_shot(2, 16'd100, -16'sd30, 16'd70);
    one_shot(1, 16'h7FFF, 16'h0001, 16'h8000);
    one_shot(3, 16'h8000, 16'hFFFF, 16'h7FFF);

    grants.delete();
    mask = '1;
    drive();
    repeat (12) step();
    drain();
    chk("rr_count", grants.size(), 12);
    for (int i = 1; i < grants.size(); i++)
      chk("rr_order", grants[i], (grants[i-1] + 1) % NCH);

    grants.delete();
    bus.m_tready = 1'b0;
    mask         = '1;
    drive();
    repeat (8) step();
    chk("bp_accepts", grants.size(), 4);
    bus.m_tready = 1'b1;
    repeat (8) step();
    drain();

    for (int i = 0; i < 60; i++) begin
      mask         = NCH'($urandom);
      bus.m_tready = 1'($urandom);
      drive();
      step();
    end
    bus.m_tready = 1'b1;
    drain();

    bus.m_tready = 1'b0;
    mask         = '1;
    drive();
    repeat (5) step();
    do_reset();
    grants.delete();
    bus.m_tready = 1'b1;
    mask         = '1;
    drive();
    step();
    chk("rst_first_grant", (grants.size() > 0) ? grants[0] : -1, 0);
    drain();
    repeat (4) step();

`ifdef STREAM_ARB_STATS_EN
    do_reset();
    mask = 4'b0010;
    drive();
    repeat (10) step();
    mask = 4'b1000;
    drive();
    repeat (5) step();
    drain();
    chk("grant_cnt0", grant_cnt[0*32 +: 32], 0);
    chk("grant_cnt1", grant_cnt[1*32 +: 32], 10);
    chk("grant_cnt2", grant_cnt[2*32 +: 32], 0);
    chk("grant_cnt3", grant_cnt[3*32 +: 32], 5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
